uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, meaning the payload bits per frame (legal range 4..16).
REQ-002 The block SHALL provide parameter CLKS_PER_BIT, default 4, meaning the clk cycles each serial bit is held (legal range >= 1).
REQ-003 The block SHALL provide parameter STOP_BITS, default 1, meaning the number of stop bits per frame (legal values 1 or 2).
REQ-004 The block SHALL provide parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity (used only with UART_TX_PARITY_EN).
REQ-005 The block SHALL provide port clk, input, 1 bit, the clock; reset rst, synchronous, active-high; clock clk.
REQ-006 The block SHALL provide port rst, input, 1 bit, the synchronous active-high reset.
REQ-007 The block SHALL provide port tx_valid, input, 1 bit, meaning a frame request.
REQ-008 The block SHALL provide port tx_data, input, DATA_W bits, meaning the payload, sampled on acceptance.
REQ-009 The block SHALL provide port tx_ready, output, 1 bit, meaning the block can accept a frame this cycle.
REQ-010 The block SHALL provide port tx, output, 1 bit, meaning the serial line (idle high).
REQ-011 The block SHALL provide port tx_busy, output, 1 bit, meaning a frame is in progress.
REQ-012 The block SHALL provide port tx_done, output, 1 bit, meaning a one-cycle pulse on frame completion.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with transitions IDLE->START->DATA->(PARITY)->STOP->IDLE.
REQ-014 tx_ready SHALL be 1 only in IDLE when rst=0; a frame is accepted on a cycle where tx_valid=1 and tx_ready=1.
REQ-015 On acceptance, tx_data SHALL be latched into a shift register; later changes to tx_data have no effect on the frame.
REQ-016 tx SHALL drive the start bit (0) starting the cycle after acceptance, so acceptance-to-line latency is 1 cycle.
REQ-017 Each bit (start, every data bit, parity, every stop bit) SHALL be held for exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1 and wraps.
REQ-018 Data bits SHALL be sent LSB first; a bit index counter 0..DATA_W-1 selects the bit and exits DATA after index DATA_W-1.
REQ-019 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 tx_done SHALL pulse high for exactly one cycle, in the last cycle of the final stop bit; the FSM enters IDLE on the next cycle.
REQ-021 tx_busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-022 tx SHALL be 1 in IDLE.
REQ-023 Back-to-back frames SHALL have at least 1 idle cycle between them (tx=1), because tx_ready is 0 during STOP.
REQ-024 tx_valid asserted while tx_busy=1 SHALL be ignored, with no queuing.
REQ-025 Total frame length SHALL be (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with parity and P=0 without.
REQ-026 tx SHALL be driven from a register with no combinational path from inputs, so it is glitch-free.

Reset
REQ-027 While rst=1, the block SHALL set: state=IDLE, tx=1, tx_busy=0, tx_done=0, tx_ready=0, counters=0, shift register=all ones.
REQ-028 rst asserted mid-frame SHALL abort the frame on the next clk edge (tx=1), with no tx_done pulse.
REQ-029 If rst and tx_valid are both 1 in the same cycle, rst SHALL win and no frame is accepted.
REQ-030 The first acceptance after reset SHALL be possible in the first cycle with rst=0.

Configuration
REQ-031 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL follow DATA and drive the XOR of the latched data bits, XORed with PARITY_ODD, for CLKS_PER_BIT cycles.
REQ-032 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, DATA SHALL go directly to STOP, and PARITY_ODD SHALL be ignored.

Verification
REQ-033 Reset check: rst=1 for 3 cycles, tx_valid=1 -> tx=1, tx_busy=0, tx_ready=0, no frame after rst drops until a new request.
REQ-034 Basic frame, defaults, no parity, data 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done at cycle 40 after acceptance; tx_busy high for 40 cycles.
REQ-035 Parity frame, UART_TX_PARITY_EN defined, data 0xA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; frame 44 cycles.
REQ-036 STOP_BITS=2, CLKS_PER_BIT=1, DATA_W=4, data 0x3 -> tx sequence 0,1,1,0,0,1,1; tx_done in cycle 7.
REQ-037 Mid-frame reset: rst pulsed 10 cycles after acceptance -> tx=1 next cycle, no tx_done, and a new frame 0x5A is sent correctly afterwards.
REQ-038 Back-to-back: tx_valid held high with data changing every cycle -> frames are separated by exactly 1 idle cycle, each frame carries the data sampled at its acceptance, and tx_valid during busy is ignored.

Source files
------------

// File: rtl/uart_tx_framer.sv
// Serial transmit framer: start bit, DATA_W payload bits LSB first, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after the payload.
module uart_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  // stop_idx value that marks the final stop bit
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_W < 4 || DATA_W > 16) begin : g_bad_data_w
    $error("DATA_W must be in 4..16");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be >= 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state_reg, state_next;
  logic [BAUD_W-1:0]   baud_reg, baud_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                stop_reg, stop_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic                tx_reg, tx_next;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_reg, parity_next;
`endif

  assign bit_end = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      idx_reg   <= '0;
      stop_reg  <= 1'b0;
      shift_reg <= '1;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      idx_reg   <= idx_next;
      stop_reg  <= stop_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // tx_next is the line value for the cycle after this one, so the line itself is a flop output.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    stop_next  = stop_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    if (state_reg == IDLE || bit_end) begin
      baud_next = '0;
    end else begin
      baud_next = baud_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_valid) begin
          state_next = START;
          shift_next = tx_data;
          idx_next   = '0;
          stop_next  = 1'b0;
          tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_reg == IDX_LAST) begin
            idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_reg;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            idx_next   = idx_reg + 1'b1;
            shift_next = {1'b1, shift_reg[DATA_W-1:1]};
            tx_next    = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (stop_reg == STOP_LAST) begin
            state_next = IDLE;
            stop_next  = 1'b0;
          end else begin
            stop_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx       = tx_reg;
  assign tx_ready = !rst && (state_reg == IDLE);
  assign tx_busy  = !rst && (state_reg != IDLE);
  assign tx_done  = !rst && (state_reg == STOP) && bit_end && (stop_reg == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: per-cycle scoreboard of expected line/handshake values.
`timescale 1ns/1ps
module tb_uart_tx_framer;

  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [10:0] EXP_SEQ = 11'b10100101010;
`else
  localparam int PB = 0;
  localparam logic [10:0] EXP_SEQ = 11'b01101001010;
`endif
  localparam int NB    = 1 + DW + PB + SB;
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx, tx_busy, tx_done;

  logic       v2 = 1'b0;
  logic [3:0] d2 = 4'h0;
  logic       ready2, tx2, busy2, done2;

  logic       v3 = 1'b0;
  logic [7:0] d3 = 8'h00;
  logic       ready3, tx3, busy3, done3;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done));

  uart_tx_framer #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(v2), .tx_data(d2),
    .tx_ready(ready2), .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  uart_tx_framer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(1)) dut3 (
    .clk(clk), .rst(rst), .tx_valid(v3), .tx_data(d3),
    .tx_ready(ready3), .tx(tx3), .tx_busy(busy3), .tx_done(done3));

  typedef struct packed {logic tx; logic busy; logic done;} exp_t;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  function automatic void push_frame(input logic [7:0] d);
    logic [15:0] fb;
    int n;
    fb = '1;
    n = 0;
    fb[n] = 1'b0; n++;
    for (int i = 0; i < DW; i++) begin fb[n] = d[i]; n++; end
    if (PB == 1) begin fb[n] = ^d; n++; end
    for (int i = 0; i < SB; i++) begin fb[n] = 1'b1; n++; end
    for (int b = 0; b < n; b++)
      for (int c = 0; c < CPB; c++)
        exp_q.push_back('{tx: fb[b], busy: 1'b1, done: (b == n - 1 && c == CPB - 1)});
  endfunction

  // One clock cycle on the main instance: drive inputs, check outputs against the model, advance.
  task automatic step(input string name, input logic r, input logic v, input logic [7:0] d);
    exp_t e;
    logic idle, exp_ready;
    logic [3:0] got, want;
    rst = r; tx_valid = v; tx_data = d;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); idle = 1'b0;
    end else begin
      e = '{tx: 1'b1, busy: 1'b0, done: 1'b0}; idle = 1'b1;
    end
    if (r) begin
      e.busy = 1'b0; e.done = 1'b0; exp_ready = 1'b0;
      exp_q.delete();
    end else begin
      exp_ready = idle;
    end
    if (!r && idle && v) push_frame(d);
    got  = {tx, tx_ready, tx_busy, tx_done};
    want = {e.tx, exp_ready, e.busy, e.done};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: tx/ready/busy/done=%b required %b", name, cyc, got, want);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step("reset", 1'b1, 1'b1, 8'hFF);
      vectors++;
      if ({tx2, ready2, busy2, done2, tx3, ready3, busy3, done3} !== 8'b1000_1000) begin
        miscompares++;
        $display("FAIL reset_aux: dut2/dut3 tx/ready/busy/done=%b required 10001000",
                 {tx2, ready2, busy2, done2, tx3, ready3, busy3, done3});
      end
    end
    for (int i = 0; i < 6; i++) step("post_reset", 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_first_accept();
    step("first_rst", 1'b1, 1'b0, 8'h00);
    step("first_accept", 1'b0, 1'b1, 8'h0F);
    for (int k = 1; k <= FRAME + 1; k++) step("first_frame", 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic test_basic();
    logic [10:0] seq;
    int done_at, busy_cnt;
    seq = '0; done_at = -1; busy_cnt = 0;
    step("basic_accept", 1'b0, 1'b1, 8'hA5);
    for (int k = 1; k <= FRAME + 1; k++) begin
      if ((k - 1) % CPB == 1 && (k - 1) / CPB < NB) seq[(k - 1) / CPB] = tx;
      if (tx_busy) busy_cnt++;
      if (tx_done) done_at = k;
      step("basic_frame", 1'b0, 1'b0, 8'($urandom));
    end
    vectors++;
    if (seq !== EXP_SEQ) begin
      miscompares++;
      $display("FAIL basic_seq: line bits %b required %b", seq, EXP_SEQ);
    end
    vectors++;
    if (done_at != FRAME) begin
      miscompares++;
      $display("FAIL basic_done: tx_done at cycle %0d required %0d", done_at, FRAME);
    end
    vectors++;
    if (busy_cnt != FRAME) begin
      miscompares++;
      $display("FAIL basic_busy: tx_busy cycles %0d required %0d", busy_cnt, FRAME);
    end
  endtask

  task automatic test_parity();
    logic q3[$];
    logic e;
    logic [7:0] d;
    d = 8'hA5;
    v3 = 1'b1; d3 = d;
    #1;
    vectors++;
    if (ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL odd_ready: tx_ready=%b required 1", ready3);
    end
    for (int c = 0; c < CPB; c++) q3.push_back(1'b0);
    for (int i = 0; i < DW; i++) for (int c = 0; c < CPB; c++) q3.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) q3.push_back((^d) ^ 1'b1);
`endif
    for (int c = 0; c < CPB * SB; c++) q3.push_back(1'b1);
    @(posedge clk); #1;
    v3 = 1'b0; d3 = 8'h00;
    for (int k = 1; k <= FRAME; k++) begin
      e = q3.pop_front();
      vectors++;
      if ({tx3, busy3, done3} !== {e, 1'b1, (k == FRAME)}) begin
        miscompares++;
        $display("FAIL odd_frame cycle %0d: tx/busy/done=%b required %b", k,
                 {tx3, busy3, done3}, {e, 1'b1, (k == FRAME)});
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({tx3, busy3, done3, ready3} !== 4'b1001) begin
      miscompares++;
      $display("FAIL odd_idle: tx/busy/done/ready=%b required 1001", {tx3, busy3, done3, ready3});
    end
  endtask

  task automatic test_stop2();
    logic q2[$];
    logic e;
    int n;
    v2 = 1'b1; d2 = 4'h3;
    #1;
    vectors++;
    if (ready2 !== 1'b1) begin
      miscompares++;
      $display("FAIL stop2_ready: tx_ready=%b required 1", ready2);
    end
    q2 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef UART_TX_PARITY_EN
    q2.push_back(1'b0);
`endif
    q2.push_back(1'b1); q2.push_back(1'b1);
    n = q2.size();
    @(posedge clk); #1;
    v2 = 1'b0; d2 = 4'hC;
    for (int k = 1; k <= n; k++) begin
      e = q2.pop_front();
      vectors++;
      if ({tx2, busy2, done2} !== {e, 1'b1, (k == n)}) begin
        miscompares++;
        $display("FAIL stop2_frame cycle %0d: tx/busy/done=%b required %b", k,
                 {tx2, busy2, done2}, {e, 1'b1, (k == n)});
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({tx2, busy2, done2, ready2} !== 4'b1001) begin
      miscompares++;
      $display("FAIL stop2_idle: tx/busy/done/ready=%b required 1001", {tx2, busy2, done2, ready2});
    end
  endtask

  task automatic test_midframe_reset();
    int done_seen;
    done_seen = 0;
    step("mid_accept", 1'b0, 1'b1, 8'h3C);
    for (int k = 1; k <= 9; k++) begin
      if (tx_done) done_seen++;
      step("mid_frame", 1'b0, 1'b0, 8'hFF);
    end
    if (tx_done) done_seen++;
    step("mid_rst", 1'b1, 1'b0, 8'h00);
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_abort_tx: tx=%b required 1", tx);
    end
    for (int k = 0; k < 3; k++) begin
      if (tx_done) done_seen++;
      step("mid_after", 1'b0, 1'b0, 8'h00);
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL mid_no_done: tx_done pulses %0d required 0", done_seen);
    end
    step("mid_new_accept", 1'b0, 1'b1, 8'h5A);
    for (int k = 1; k <= FRAME + 1; k++) step("mid_new_frame", 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    for (int k = 0; k < 150; k++) begin
      if (tx_done) dones++;
      step("b2b", 1'b0, 1'b1, 8'($urandom));
    end
    vectors++;
    if (dones != 3) begin
      miscompares++;
      $display("FAIL b2b_frames: completed frames %0d required 3", dones);
    end
    for (int k = 0; k < FRAME + 2; k++) step("b2b_drain", 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_first_accept();
    test_basic();
    test_parity();
    test_stop2();
    test_midframe_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
